// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder:
//   - dmem_state_e : transaction FSM states (IDLE / WAIT / RESP)
//   - DATA_W       : memory line width (8 bits)
//   - RD_LAT_MIN/MAX, CNT_W : legal access-latency range and counter width
//   - even_parity  : parity bit that makes {data, parity} have even weight
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DATA_W     = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 7;
    // Counter holds at most RD_LAT_MAX-1 = 6.
    localparam int CNT_W      = 3;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Reset-cleared register array of DEPTH lines x DATA_W bits with a
// combinational read port and a single synchronous write port sharing addr.
// Optional feature macro: DMEM_PARITY_EN -- adds one even-parity bit per
// line, a parity_inject input that inverts the stored bit on a write, and a
// parity_err output flagging a mismatch on the line currently addressed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all lines)
//   we              write enable (one-cycle)
//   addr            line address
//   wdata           write data
//   parity_inject   (DMEM_PARITY_EN only) invert stored parity on this write
//   rdata           read data of line addr (combinational)
//   parity_err      (DMEM_PARITY_EN only) recomputed parity != stored parity
// ----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 16
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
`ifdef DMEM_PARITY_EN
    input  logic                     parity_inject,
    output logic                     parity_err,
`endif
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] lines_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lines_q[i] <= '0;
            end
        end else if (we) begin
            lines_q[addr] <= wdata;
        end
    end

    assign rdata = lines_q[addr];

`ifdef DMEM_PARITY_EN
    logic [DEPTH-1:0] par_q;

    // A cleared line (all zeros) has even parity 0, so reset is consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (we) begin
            par_q[addr] <= even_parity(wdata) ^ parity_inject;
        end
    end

    assign parity_err = even_parity(lines_q[addr]) ^ par_q[addr];
`endif

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding-request memory responder. A request (exactly one of
// mem_read / mem_write high in IDLE) is latched, waits RD_LAT cycles, is
// committed on the WAIT->RESP edge and acknowledged with a one-cycle
// mem_ready in RESP. mem_ready rises RD_LAT+1 cycles after the request cycle.
// Handshake: the initiator holds nothing; a strobe is sampled only in IDLE.
// Strobes seen in WAIT/RESP are dropped silently; the initiator must wait
// for mem_ready before issuing the next request. Both strobes together in
// IDLE are rejected with a one-cycle mem_err and no access.
// Optional feature macro: DMEM_PARITY_EN (per-line parity, parity_inject
// port, mem_err also raised with mem_ready on a parity-mismatching read).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_read        read request strobe
//   mem_write       write request strobe
//   line_number     line address (implicitly modulo DEPTH)
//   mem_in          write data
//   parity_inject   (DMEM_PARITY_EN only) invert stored parity on a write
//   mem_out         registered read data, held until the next read completes
//   mem_ready       one-cycle completion pulse
//   mem_busy        high in WAIT and RESP
//   mem_err         one-cycle error pulse
// Parameters: DEPTH (power of two, 2..256), RD_LAT (1..7).
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 2
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [$clog2(DEPTH)-1:0] line_number,
    input  logic [DATA_W-1:0]        mem_in,
`ifdef DMEM_PARITY_EN
    input  logic                     parity_inject,
`endif
    output logic [DATA_W-1:0]        mem_out,
    output logic                     mem_ready,
    output logic                     mem_busy,
    output logic                     mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_write_q;
    logic [AW-1:0]     line_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              accept;
    logic              dual_strobe;
    logic              done;
    logic              array_we;
    logic [DATA_W-1:0] array_rdata;
    logic              rd_parity_err;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_read ^ mem_write) state_d = WAIT;
            WAIT:    if (cnt_q == '0)          state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / control ----------------
    always_comb begin
        mem_busy    = 1'b0;
        mem_ready   = 1'b0;
        accept      = 1'b0;
        dual_strobe = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                accept      = mem_read ^ mem_write;
                dual_strobe = mem_read & mem_write;
            end
            WAIT: begin
                mem_busy = 1'b1;
                done     = (cnt_q == '0);
            end
            RESP: begin
                mem_busy  = 1'b1;
                mem_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign array_we = done & op_write_q;

    // ---------------- request latch, counter, read data, error ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            line_q     <= '0;
            data_q     <= '0;
            mem_out    <= '0;
            err_q      <= 1'b0;
        end else begin
            // Error is a pulse: cleared unless re-raised on this edge.
            err_q <= dual_strobe;
            if (accept) begin
                op_write_q <= mem_write;
                line_q     <= line_number;
                data_q     <= mem_in;
                cnt_q      <= CNT_LOAD;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done && !op_write_q) begin
                mem_out <= array_rdata;
                // Lands in RESP, i.e. together with mem_ready.
                err_q   <= rd_parity_err;
            end
        end
    end

    assign mem_err = err_q;

`ifdef DMEM_PARITY_EN
    logic inject_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inject_q <= 1'b0;
        end else if (accept) begin
            inject_q <= parity_inject;
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk           (clk),
        .rst_n         (rst_n),
        .we            (array_we),
        .addr          (line_q),
        .wdata         (data_q),
        .parity_inject (inject_q),
        .parity_err    (rd_parity_err),
        .rdata         (array_rdata)
    );
`else
    assign rd_parity_err = 1'b0;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (array_we),
        .addr  (line_q),
        .wdata (data_q),
        .rdata (array_rdata)
    );
`endif

endmodule
